// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a common-anode 8-digit 7-segment display with per-frame snapshot and anti-ghost blanking.
// Optional leading-zero suppression per 4-digit group when SEG7_ZERO_SUPPRESS_EN is defined.
module seg7_scan_driver #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int SCAN_HZ   = 8_000,
    parameter int BLANK_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] display,
    input  logic [7:0]  displayEnable,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_PRE   = CW'(DIV - 2);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [31:0]   shadow_disp;
    logic [7:0]    shadow_en;
    logic          tick;
    logic [3:0]    nib;
    logic          suppress;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0:    hex7 = 7'h40;
            4'h1:    hex7 = 7'h79;
            4'h2:    hex7 = 7'h24;
            4'h3:    hex7 = 7'h30;
            4'h4:    hex7 = 7'h19;
            4'h5:    hex7 = 7'h12;
            4'h6:    hex7 = 7'h02;
            4'h7:    hex7 = 7'h78;
            4'h8:    hex7 = 7'h00;
            4'h9:    hex7 = 7'h10;
            4'hA:    hex7 = 7'h08;
            4'hB:    hex7 = 7'h03;
            4'hC:    hex7 = 7'h46;
            4'hD:    hex7 = 7'h21;
            4'hE:    hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    assign tick = (cnt == CNT_LAST);
    assign nib  = shadow_disp[{idx, 2'b00} +: 4];
    assign dp   = 1'b1;

`ifdef SEG7_ZERO_SUPPRESS_EN
    logic above_zero;

    // A digit is a leading zero when no enabled digit above it in its group is nonzero.
    always_comb begin
        above_zero = 1'b1;
        for (int j = 0; j < 8; j++) begin
            if ((3'(j) > idx) && (3'(j) <= {idx[2], 2'b11}) &&
                shadow_en[j] && (shadow_disp[4*j +: 4] != 4'h0)) begin
                above_zero = 1'b0;
            end
        end
        suppress = above_zero && (nib == 4'h0) && (idx[1:0] != 2'b00);
    end
`else
    assign suppress = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= '0;
            idx         <= 3'd0;
            shadow_disp <= 32'h0;
            shadow_en   <= 8'h0;
            an          <= 8'hFF;
            seg         <= 7'h7F;
            frame_tick  <= 1'b0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
                idx <= idx + 1'b1;
                if (idx == 3'd7) begin
                    shadow_disp <= display;
                    shadow_en   <= displayEnable;
                end
            end
            // Registered one cycle early so the pulse coincides with the snapshot clock.
            frame_tick <= (cnt == CNT_PRE) && (idx == 3'd7);
            if (cnt < CNT_BLANK) begin
                an  <= 8'hFF;
                seg <= 7'h7F;
            end else begin
                an  <= (shadow_en[idx] && !suppress) ? ~(8'b1 << idx) : 8'hFF;
                seg <= hex7(nib);
            end
        end
    end

endmodule
